regfile_mp_sb: RTL
==================

# regfile_mp_sb

Parametrised multi-port general-purpose register file with an integrated busy-bit scoreboard, for the dual-issue pipeline. It holds the architectural integer registers, serves NUM_READ combinational read ports with write-back bypass, accepts NUM_WRITE write-back ports per cycle, and tracks pending producers per register so issue logic can stall on unready operands. Register 0 is hardwired to zero and never busy.

## Interface
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, number of registers (power of two, ≥2); AW = $clog2(NUM_REGS)
- NUM_READ, 4, read ports
- NUM_WRITE, 2, write-back ports; higher index = younger instruction
- NUM_RSV, 2, destination-reservation ports from issue

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- we  in  NUM_WRITE  per-port write enable
- waddr  in  NUM_WRITE*AW  write addresses, port i at [i*AW +: AW]
- wdata  in  NUM_WRITE*DATA_WIDTH  write data
- rsv_en  in  NUM_RSV  per-port reserve (mark destination busy)
- rsv_addr  in  NUM_RSV*AW  reserve addresses
- flush  in  1  pipeline flush: clear all busy bits
- re  in  NUM_READ  per-port read enable
- raddr  in  NUM_READ*AW  read addresses
- rdata  out  NUM_READ*DATA_WIDTH  read data
- rvalid  out  NUM_READ  operand ready for port
- busy  out  NUM_REGS  registered scoreboard, bit n = register n pending
- debug_reg  out  NUM_REGS*DATA_WIDTH  flat register dump, reg n at [n*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Storage: NUM_REGS × DATA_WIDTH flops plus NUM_REGS busy flops.
- Write: on edge, for each port i with we[i] and waddr≠0, regs[waddr] <= wdata. Same address on several ports: highest port index wins.
- Busy set: rsv_en[j] with rsv_addr≠0 sets busy[rsv_addr]. Reserve of r0 ignored.
- Busy clear: we[i] with waddr≠0 clears busy[waddr].
- Same-cycle priority per register: flush > reserve > write-back clear. Reserve and write-back to same register in one cycle: data written, busy ends 1 (younger producer pending). Flush: all busy bits 0 next cycle; writes in the flush cycle still commit.
- Read port k (combinational), priority order:
  - rst high: rdata 0, rvalid 0.
  - re[k]=0: rdata 0, rvalid 0.
  - raddr=0: rdata 0, rvalid 1.
  - Bypass: any we[i] with waddr[i]=raddr[k]: rdata = wdata of highest such i, rvalid 1.
  - Else rdata = regs[raddr], rvalid = !busy[raddr].
- Reservations in the current cycle do not affect rvalid in that cycle (issue logic handles intra-bundle dependences).
- debug_reg and busy reflect flop state only, never bypass.

## Timing
- Reset (async assert): all regs 0, all busy 0 immediately; rdata 0, rvalid 0, busy 0, debug_reg 0 while rst high. Deassert is synchronised externally; first edge after deassert may update state.
- Read latency 0 cycles (combinational from raddr/re/we/waddr/wdata/busy).
- Write visible in regs/debug_reg after the next rising edge; same-cycle visible to readers only via bypass.
- Reserve: busy bit high from cycle N+1 for rsv_en in cycle N.
- Write-back clear: busy low from cycle N+1 for we in cycle N; rvalid already 1 in cycle N via bypass.
- Reset mid-operation: all pending reserves and writes discarded; no partial state kept.

## Test plan
- Reset: drive writes, assert rst asynchronously mid-cycle -> rdata/debug_reg/busy all 0 immediately; after release read r5 with re -> rdata 0, rvalid 1.
- Write/read and r0: write 0xDEADBEEF to r5 port0 and 0x1234 to r0 port1 -> next cycle r5 = 0xDEADBEEF, r0 reads 0, rvalid 1.
- Same-address collision: port0 writes r7=0x11, port1 writes r7=0x22 same cycle -> bypass read 0x22 in-cycle, stored 0x22 next cycle.
- Scoreboard: reserve r9 cycle 0 -> cycle 1 busy[9]=1, read r9 rvalid 0; write r9=0x55 cycle 3 -> cycle 3 rdata 0x55 rvalid 1 via bypass, cycle 4 busy[9]=0.
- Reserve vs write-back vs flush: cycle N reserve r3 and write r3=0xA -> N+1 busy[3]=1, r3=0xA; reserve r4 with flush same cycle -> busy all 0, writes in that cycle committed.
- Disabled port: re[2]=0 with raddr=r5 holding 0xDEADBEEF -> rdata 0, rvalid 0.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write-back bypass and busy-bit scoreboard
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   we_i/waddr_i/wdata_i       NUM_WRITE write-back ports (higher index = younger)
//   rsv_en_i/rsv_addr_i        NUM_RSV destination reservations (set busy)
//   flush_i                    clears every busy bit
//   re_i/raddr_i               NUM_READ combinational read ports
//   rdata_o/rvalid_o           read data and operand-ready per port
//   busy_o                     registered scoreboard
//   debug_reg_o                flat dump of register state
module regfile_mp_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 4,
    parameter int NUM_WRITE  = 2,
    parameter int NUM_RSV    = 2,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_WRITE-1:0]            we_i,
    input  logic [NUM_WRITE*AW-1:0]         waddr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_RSV-1:0]              rsv_en_i,
    input  logic [NUM_RSV*AW-1:0]           rsv_addr_i,
    input  logic                            flush_i,
    input  logic [NUM_READ-1:0]             re_i,
    input  logic [NUM_READ*AW-1:0]          raddr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rdata_o,
    output logic [NUM_READ-1:0]             rvalid_o,
    output logic [NUM_REGS-1:0]             busy_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0]  debug_reg_o
);
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    // Later assignments override earlier ones: write clear < reserve < flush,
    // and ascending port order lets the youngest write win.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NUM_WRITE; i++)
            if (we_i[i] && waddr_i[i*AW +: AW] != '0) begin
                regs_d[waddr_i[i*AW +: AW]] = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                busy_d[waddr_i[i*AW +: AW]] = 1'b0;
            end
        for (int j = 0; j < NUM_RSV; j++)
            if (rsv_en_i[j] && rsv_addr_i[j*AW +: AW] != '0)
                busy_d[rsv_addr_i[j*AW +: AW]] = 1'b1;
        if (flush_i)
            busy_d = '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end
    assign busy_o = busy_q;
    for (genvar n = 0; n < NUM_REGS; n++) begin : g_dbg
        assign debug_reg_o[n*DATA_WIDTH +: DATA_WIDTH] = regs_q[n];
    end
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [AW-1:0]         ra;
        logic                  hit;
        logic [DATA_WIDTH-1:0] bd;
        assign ra = raddr_i[k*AW +: AW];
        // Bypass picks the youngest matching write-back port.
        always_comb begin
            hit = 1'b0;
            bd  = '0;
            for (int i = 0; i < NUM_WRITE; i++)
                if (we_i[i] && waddr_i[i*AW +: AW] == ra) begin
                    hit = 1'b1;
                    bd  = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
        end
        assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] =
            (rst || !re_i[k] || ra == '0) ? '0 : hit ? bd : regs_q[ra];
        assign rvalid_o[k] = !rst && re_i[k] && (ra == '0 || hit || !busy_q[ra]);
    end
endmodule
